uart_packet_ctrl: RTL and testbench

//  Sequences the byte stream from the UART receiver into framed command packets.

---
 rtl/uart_packet_ctrl_pkg.sv | 28 ++
 rtl/uart_packet_ctrl_pkt_buffer.sv | 36 +++
 rtl/uart_packet_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_uart_packet_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_packet_ctrl_pkg.sv
// Shared types and constants for the UART packet controller: FSM states, error codes,
// clock/baud defaults shared with the receiver, and the timeout-length helper.
package uart_packet_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_HUNT    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CHECK   = 3'd3,
    ST_DRAIN   = 3'd4
  } state_e;

  localparam logic [1:0] ERR_CHK = 2'd0;
  localparam logic [1:0] ERR_LEN = 2'd1;
  localparam logic [1:0] ERR_TMO = 2'd2;
  localparam logic [1:0] ERR_OVR = 2'd3;

  localparam logic [31:0] DEFAULT_FREQUENCY = 32'd50_000_000;
  localparam logic [31:0] DEFAULT_SPEED     = 32'd9600;

  // Inter-byte timeout expressed in system clock cycles.
  function automatic logic [31:0] timeout_cycles(input logic [31:0] freq,
                                                 input logic [31:0] speed,
                                                 input logic [31:0] bits);
    return (freq / speed) * bits;
  endfunction

endpackage

// File: rtl/uart_packet_ctrl_pkt_buffer.sv
// Payload store for one frame: DEPTH x 8 register array with a single write port and a
// registered read port (rdata follows raddr one cycle later).
module uart_packet_ctrl_pkt_buffer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_q;

  // The array itself is never reset; only the read register is, so the output reads 0.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= 8'h00;
    end else begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/uart_packet_ctrl.sv
// Frames the UART receiver byte stream (SYNC, LEN, payload, CHK), verifies the XOR
// checksum and streams the buffered payload to the command decoder over valid/ready.
module uart_packet_ctrl
  import uart_packet_ctrl_pkg::*;
#(
  parameter logic [31:0] FREQUENCY    = DEFAULT_FREQUENCY,
  parameter logic [31:0] SPEED        = DEFAULT_SPEED,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int          MAX_LEN      = 16,
  parameter logic [31:0] TIMEOUT_BITS = 32'd30
) (
  input  logic       CLK_i,
  input  logic       reset_ni,
  input  logic       rx_ready_i,
  input  logic [7:0] rx_data_i,
  output logic [7:0] pkt_data_o,
  output logic       pkt_valid_o,
  input  logic       pkt_ready_i,
  output logic       pkt_last_o,
  output logic       pkt_err_o,
  output logic [1:0] err_code_o
);

  localparam int          AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [31:0] TMO_LIMIT = timeout_cycles(FREQUENCY, SPEED, TIMEOUT_BITS);

  state_e      state_q, state_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  chk_q, chk_d;
  logic [7:0]  wPtr_q, wPtr_d;
  logic [7:0]  rPtr_q, rPtr_d;
  logic [31:0] tmoCnt_q, tmoCnt_d;
  logic        rxReady_q;
  logic        valid_q, valid_d;
  logic        last_q, last_d;
  logic        err_q, err_d;
  logic [1:0]  errCode_q, errCode_d;

  logic        byteEvent;
  logic        inFrame;
  logic        bufWe;
  logic [7:0]  bufRdata;

  assign byteEvent = rx_ready_i & ~rxReady_q;
  assign inFrame   = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CHECK);

  uart_packet_ctrl_pkt_buffer #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk_i   (CLK_i),
    .rst_ni  (reset_ni),
    .we_i    (bufWe),
    .waddr_i (wPtr_q[AW-1:0]),
    .wdata_i (rx_data_i),
    .raddr_i (rPtr_d[AW-1:0]),
    .rdata_o (bufRdata)
  );

  always_ff @(posedge CLK_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= ST_HUNT;
      len_q     <= 8'h00;
      chk_q     <= 8'h00;
      wPtr_q    <= 8'h00;
      rPtr_q    <= 8'h00;
      tmoCnt_q  <= 32'd0;
      rxReady_q <= 1'b0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      err_q     <= 1'b0;
      errCode_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      chk_q     <= chk_d;
      wPtr_q    <= wPtr_d;
      rPtr_q    <= rPtr_d;
      tmoCnt_q  <= tmoCnt_d;
      rxReady_q <= rx_ready_i;
      valid_q   <= valid_d;
      last_q    <= last_d;
      err_q     <= err_d;
      errCode_q <= errCode_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    chk_d     = chk_q;
    wPtr_d    = wPtr_q;
    rPtr_d    = rPtr_q;
    tmoCnt_d  = 32'd0;
    valid_d   = 1'b0;
    last_d    = 1'b0;
    err_d     = 1'b0;
    errCode_d = errCode_q;
    bufWe     = 1'b0;

    case (state_q)
      ST_HUNT: begin
        if (byteEvent && (rx_data_i == SYNC_BYTE)) begin
          state_d = ST_LEN;
        end
      end
      ST_LEN: begin
        if (byteEvent) begin
          if ((rx_data_i == 8'h00) || (rx_data_i > MAX_LEN_B)) begin
            err_d     = 1'b1;
            errCode_d = ERR_LEN;
            state_d   = ST_HUNT;
          end else begin
            len_d   = rx_data_i;
            chk_d   = rx_data_i;
            wPtr_d  = 8'h00;
            state_d = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (byteEvent) begin
          bufWe  = 1'b1;
          chk_d  = chk_q ^ rx_data_i;
          wPtr_d = wPtr_q + 8'd1;
          if (wPtr_q == (len_q - 8'd1)) begin
            state_d = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        if (byteEvent) begin
          if (rx_data_i == chk_q) begin
            rPtr_d  = 8'h00;
            state_d = ST_DRAIN;
          end else begin
            err_d     = 1'b1;
            errCode_d = ERR_CHK;
            state_d   = ST_HUNT;
          end
        end
      end
      ST_DRAIN: begin
        valid_d = 1'b1;
        // A byte arriving while the previous payload is still draining has nowhere to go.
        if (byteEvent) begin
          err_d     = 1'b1;
          errCode_d = ERR_OVR;
        end
        if (valid_q && pkt_ready_i) begin
          if (last_q) begin
            valid_d = 1'b0;
            state_d = ST_HUNT;
          end else begin
            rPtr_d = rPtr_q + 8'd1;
          end
        end
        last_d = valid_d && (rPtr_d == (len_q - 8'd1));
      end
      default: begin
        state_d = ST_HUNT;
      end
    endcase

    // A byte in the same cycle as expiry wins: the counter clears instead of firing.
    if (inFrame && !byteEvent) begin
      if (tmoCnt_q == (TMO_LIMIT - 32'd1)) begin
        err_d     = 1'b1;
        errCode_d = ERR_TMO;
        state_d   = ST_HUNT;
      end else begin
        tmoCnt_d = tmoCnt_q + 32'd1;
      end
    end
  end

  assign pkt_data_o  = bufRdata;
  assign pkt_valid_o = valid_q;
  assign pkt_last_o  = last_q;
  assign pkt_err_o   = err_q;
  assign err_code_o  = errCode_q;

endmodule

// File: tb/tb_uart_packet_ctrl.sv
// Scoreboard bench for uart_packet_ctrl: stimulus pushes expected payload bytes and error
// codes into queues, and a negedge monitor pops and compares whenever the DUT presents them.
module tb_uart_packet_ctrl;

  localparam logic [31:0] FREQ  = 32'd1000;
  localparam logic [31:0] SPD   = 32'd100;
  localparam logic [31:0] TBITS = 32'd30;
  localparam int          LIMIT = 300;

  logic       CLK = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       pkt_ready = 1'b1;
  logic [7:0] pkt_data;
  logic       pkt_valid;
  logic       pkt_last;
  logic       pkt_err;
  logic [1:0] err_code;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int lastByteCyc = 0;

  logic [8:0] expData[$];
  logic [1:0] expErr[$];
  logic       prevHold = 1'b0;
  logic [7:0] prevData = 8'h00;

  uart_packet_ctrl #(
    .FREQUENCY    (FREQ),
    .SPEED        (SPD),
    .SYNC_BYTE    (8'hA5),
    .MAX_LEN      (16),
    .TIMEOUT_BITS (TBITS)
  ) dut (
    .CLK_i       (CLK),
    .reset_ni    (reset_n),
    .rx_ready_i  (rx_ready),
    .rx_data_i   (rx_data),
    .pkt_data_o  (pkt_data),
    .pkt_valid_o (pkt_valid),
    .pkt_ready_i (pkt_ready),
    .pkt_last_o  (pkt_last),
    .pkt_err_o   (pkt_err),
    .err_code_o  (err_code)
  );

  // Free-running clock and cycle counter used for timeout timing.
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  // Records one comparison and reports it if the values differ.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Presents one byte on the receiver interface, keeping rx_ready high for 'hold' cycles.
  task automatic applyStimulus(input logic [7:0] b, input int hold);
    @(negedge CLK);
    rx_data  = b;
    rx_ready = 1'b1;
    @(posedge CLK);
    #1 lastByteCyc = cyc;
    repeat (hold - 1) @(posedge CLK);
    @(negedge CLK);
    rx_ready = 1'b0;
  endtask

  task automatic sendFrame3(input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2,
                            input logic [7:0] chk, input int hold);
    applyStimulus(8'hA5, hold);
    applyStimulus(8'h03, hold);
    applyStimulus(p0, hold);
    applyStimulus(p1, hold);
    applyStimulus(p2, hold);
    applyStimulus(chk, hold);
  endtask

  // CHK = 03 ^ 11 ^ 22 ^ 33 = 03 for the reference frame.
  task automatic expectRef();
    expData.push_back({1'b0, 8'h11});
    expData.push_back({1'b0, 8'h22});
    expData.push_back({1'b1, 8'h33});
  endtask

  // Waits, with a cycle budget, until every expected item has been observed.
  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    while (((expData.size() + expErr.size()) != 0) && (n < budget)) begin
      @(posedge CLK);
      n++;
    end
    checkOutput("pending_items", 32'(expData.size() + expErr.size()), 32'd0);
    repeat (8) @(posedge CLK);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_valid"}, 32'(pkt_valid), 32'd0);
    checkOutput({tag, "_last"}, 32'(pkt_last), 32'd0);
    checkOutput({tag, "_err"}, 32'(pkt_err), 32'd0);
    checkOutput({tag, "_code"}, 32'(err_code), 32'd0);
    checkOutput({tag, "_data"}, 32'(pkt_data), 32'd0);
  endtask

  // Monitor: compares handshaken bytes and error pulses against the scoreboard queues.
  always @(negedge CLK) begin
    logic [8:0] ed;
    logic [1:0] ee;
    if (!reset_n) begin
      prevHold = 1'b0;
    end else begin
      if (prevHold && pkt_valid) begin
        checkOutput("hold_stable", 32'(pkt_data), 32'(prevData));
      end
      if (pkt_valid && pkt_ready) begin
        if (expData.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_data: got %0h expected none at %0t", pkt_data, $time);
        end else begin
          ed = expData.pop_front();
          checkOutput("data_last", 32'({pkt_last, pkt_data}), 32'(ed));
        end
      end
      if (pkt_err) begin
        if (expErr.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_err: got code %0d expected none at %0t", err_code, $time);
        end else begin
          ee = expErr.pop_front();
          checkOutput("err_code", 32'(err_code), 32'(ee));
          if (ee == 2'd2) begin
            checkOutput("tmo_cycles", 32'(cyc - lastByteCyc), 32'(LIMIT));
          end
        end
      end
      prevHold = pkt_valid && !pkt_ready;
      prevData = pkt_data;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no finish expected finish at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(posedge CLK);
    #1 checkResetOutputs("reset");
    @(posedge CLK);
    #2 reset_n = 1'b1;

    // Reference frame drains 11, 22, 33 with last on 33.
    expectRef();
    sendFrame3(8'h11, 8'h22, 8'h33, 8'h03, 1);
    waitIdle(200);

    // Wrong checksums drop the frame; a good frame afterwards is accepted.
    expErr.push_back(2'd0);
    sendFrame3(8'h11, 8'h22, 8'h33, 8'h01, 1);
    waitIdle(200);
    expErr.push_back(2'd0);
    sendFrame3(8'h11, 8'h22, 8'h33, 8'h00, 1);
    waitIdle(200);
    expectRef();
    sendFrame3(8'h11, 8'h22, 8'h33, 8'h03, 1);
    waitIdle(200);

    // Length 0 and length 17 are rejected; code stays 1 until the next error.
    expErr.push_back(2'd1);
    applyStimulus(8'hA5, 1);
    applyStimulus(8'h00, 1);
    waitIdle(100);
    expErr.push_back(2'd1);
    applyStimulus(8'hA5, 1);
    applyStimulus(8'h11, 1);
    waitIdle(100);
    checkOutput("len_code_held", 32'(err_code), 32'd1);

    // Length 1 (01 ^ 7E = 7F) and length 16 (payload 01..10, chk 00).
    expData.push_back({1'b1, 8'h7E});
    applyStimulus(8'hA5, 1);
    applyStimulus(8'h01, 1);
    applyStimulus(8'h7E, 1);
    applyStimulus(8'h7F, 1);
    waitIdle(100);
    applyStimulus(8'hA5, 1);
    applyStimulus(8'h10, 1);
    for (int i = 1; i <= 16; i++) begin
      expData.push_back({(i == 16), 8'(i)});
      applyStimulus(8'(i), 1);
    end
    applyStimulus(8'h00, 1);
    waitIdle(200);

    // Silence after a partial frame times out exactly LIMIT cycles after the last byte.
    expErr.push_back(2'd2);
    applyStimulus(8'hA5, 1);
    applyStimulus(8'h03, 1);
    applyStimulus(8'h11, 1);
    repeat (310) @(posedge CLK);
    waitIdle(50);
    expectRef();
    sendFrame3(8'h11, 8'h22, 8'h33, 8'h03, 1);
    waitIdle(200);

    // Stalled consumer: an extra byte during drain is an overrun, data stays put.
    @(posedge CLK);
    #1 pkt_ready = 1'b0;
    expectRef();
    sendFrame3(8'h11, 8'h22, 8'h33, 8'h03, 1);
    repeat (100) @(posedge CLK);
    #1 checkOutput("ovr_valid", 32'(pkt_valid), 32'd1);
    checkOutput("ovr_data_before", 32'(pkt_data), 32'h11);
    expErr.push_back(2'd3);
    applyStimulus(8'h55, 1);
    repeat (3) @(posedge CLK);
    #1 checkOutput("ovr_data_after", 32'(pkt_data), 32'h11);
    checkOutput("ovr_code", 32'(err_code), 32'd3);
    @(posedge CLK);
    #1 pkt_ready = 1'b1;
    waitIdle(200);

    // rx_ready held for 5 cycles per byte must still count as one byte each.
    expectRef();
    sendFrame3(8'h11, 8'h22, 8'h33, 8'h03, 5);
    waitIdle(200);

    // Reset in the middle of the payload clears outputs (including held code 3).
    applyStimulus(8'hA5, 1);
    applyStimulus(8'h03, 1);
    applyStimulus(8'h11, 1);
    @(posedge CLK);
    #2 reset_n = 1'b0;
    #1 checkResetOutputs("rst_payload");
    @(posedge CLK);
    #2 reset_n = 1'b1;
    applyStimulus(8'h22, 1);
    applyStimulus(8'h33, 1);
    applyStimulus(8'h03, 1);
    repeat (10) @(posedge CLK);
    expectRef();
    sendFrame3(8'h11, 8'h22, 8'h33, 8'h03, 1);
    waitIdle(200);

    // Reset while draining drops valid without waiting for a clock edge.
    @(posedge CLK);
    #1 pkt_ready = 1'b0;
    sendFrame3(8'h11, 8'h22, 8'h33, 8'h03, 1);
    repeat (3) @(posedge CLK);
    #1 checkOutput("drain_valid", 32'(pkt_valid), 32'd1);
    @(posedge CLK);
    #2 reset_n = 1'b0;
    #1 checkResetOutputs("rst_drain");
    @(posedge CLK);
    #2 reset_n = 1'b1;
    pkt_ready = 1'b1;
    expectRef();
    sendFrame3(8'h11, 8'h22, 8'h33, 8'h03, 1);
    waitIdle(200);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
